// File: rtl/pipe_addsub_pkg.sv
// Shared definitions for the pipe_addsub arithmetic pipeline.
// Holds the operation encoding sampled alongside the operands.
package pipe_addsub_pkg;

    localparam int unsigned OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_ADD_WRAP = 2'b00,
        OP_SUB_WRAP = 2'b01,
        OP_ADD_SAT  = 2'b10,
        OP_SUB_SAT  = 2'b11
    } op_e;

endpackage

// File: rtl/pipe_addsub_stage.sv
// One valid/ready register slice of the pipeline.
// Loads whenever it is empty or its successor takes the current entry.
module pipe_addsub_stage #(
    parameter int unsigned DW = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          in_valid,
    output logic          in_ready_c,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    logic          valid_q;
    logic          valid_d;
    logic [DW-1:0] data_q;
    logic [DW-1:0] data_d;

    // Data only moves on an actual load so a stalled output stays stable.
    always_comb begin
        valid_d    = valid_q;
        data_d     = data_q;
        in_ready_c = !valid_q || out_ready;
        if (in_ready_c) begin
            valid_d = in_valid;
            if (in_valid) begin
                data_d = in_data;
            end
        end
        if (clr) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/pipe_addsub.sv
// Handshaked add/subtract pipeline with wrap/saturate modes, carry/borrow flag
// and a saturating count of delivered overflowing results.
module pipe_addsub
    import pipe_addsub_pkg::*;
#(
    parameter int unsigned W      = 8,
    parameter int unsigned STAGES = 2,
    parameter int unsigned CW     = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    a,
    input  logic [W-1:0]    b,
    input  logic [OP_W-1:0] op,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    y,
    output logic            ovf,
    input  logic            cnt_clr,
    output logic [CW-1:0]   ovf_cnt
);

    localparam int unsigned DW = W + 1;

    logic [W:0]   sum_c;
    logic [W:0]   diff_c;
    logic [W-1:0] res_y_c;
    logic         res_ovf_c;

    // Extended-width add/sub: the top bit is the carry or the borrow (a < b).
    always_comb begin
        sum_c     = {1'b0, a} + {1'b0, b};
        diff_c    = {1'b0, a} - {1'b0, b};
        res_y_c   = sum_c[W-1:0];
        res_ovf_c = sum_c[W];
        unique case (op_e'(op))
            OP_ADD_WRAP: begin
                res_y_c   = sum_c[W-1:0];
                res_ovf_c = sum_c[W];
            end
            OP_SUB_WRAP: begin
                res_y_c   = diff_c[W-1:0];
                res_ovf_c = diff_c[W];
            end
            OP_ADD_SAT: begin
                res_y_c   = sum_c[W] ? '1 : sum_c[W-1:0];
                res_ovf_c = sum_c[W];
            end
            OP_SUB_SAT: begin
                res_y_c   = diff_c[W] ? '0 : diff_c[W-1:0];
                res_ovf_c = diff_c[W];
            end
            default: begin
                res_y_c   = sum_c[W-1:0];
                res_ovf_c = sum_c[W];
            end
        endcase
    end

    logic [STAGES:0]         vld;
    logic [STAGES:0]         rdy;
    logic [STAGES:0][DW-1:0] dat;

    // Flush blocks acceptance; the stages themselves drop their valids.
    assign vld[0]      = in_valid && !flush;
    assign dat[0]      = {res_ovf_c, res_y_c};
    assign rdy[STAGES] = out_ready;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        pipe_addsub_stage #(
            .DW(DW)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .clr       (flush),
            .in_valid  (vld[i]),
            .in_ready_c(rdy[i]),
            .in_data   (dat[i]),
            .out_valid (vld[i+1]),
            .out_ready (rdy[i+1]),
            .out_data  (dat[i+1])
        );
    end

    assign in_ready  = rdy[0] && !flush;
    assign out_valid = vld[STAGES];
    assign ovf       = dat[STAGES][W];
    assign y         = dat[STAGES][W-1:0];

    logic [CW-1:0] ovf_cnt_q;
    logic [CW-1:0] ovf_cnt_d;

    // Clear wins over a same-cycle increment; the count sticks at all-ones.
    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (cnt_clr) begin
            ovf_cnt_d = '0;
        end else if (out_valid && out_ready && ovf && (ovf_cnt_q != '1)) begin
            ovf_cnt_d = ovf_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign ovf_cnt = ovf_cnt_q;

endmodule

// File: tb/tb_pipe_addsub.sv
// Directed bench for pipe_addsub (W=8, STAGES=2, CW=4): vector table plus
// hand-written backpressure, flush, counter and reset sequences.
module tb_pipe_addsub;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
    logic       flush;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] y;
    logic       ovf;
    logic       cnt_clr;
    logic [3:0] ovf_cnt;

    int checks   = 0;
    int failures = 0;
    int cnt_m    = 0;

    typedef struct {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] y;
        logic       ovf;
    } vec_t;

    vec_t vecs [12];
    int   expq [$];

    pipe_addsub #(.W(8), .STAGES(2), .CW(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .op       (op),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .y        (y),
        .ovf      (ovf),
        .cnt_clr  (cnt_clr),
        .ovf_cnt  (ovf_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat_inc(input int c);
        return (c < 15) ? c + 1 : 15;
    endfunction

    initial begin
        int s;
        bit seen;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = '0;
        flush = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;

        vecs[0]  = '{2'b00, 8'd200, 8'd100, 8'd44,  1'b1};
        vecs[1]  = '{2'b10, 8'd200, 8'd100, 8'd255, 1'b1};
        vecs[2]  = '{2'b11, 8'd5,   8'd9,   8'd0,   1'b1};
        vecs[3]  = '{2'b01, 8'd5,   8'd9,   8'd252, 1'b1};
        vecs[4]  = '{2'b00, 8'd3,   8'd4,   8'd7,   1'b0};
        vecs[5]  = '{2'b01, 8'd9,   8'd5,   8'd4,   1'b0};
        vecs[6]  = '{2'b10, 8'd255, 8'd0,   8'd255, 1'b0};
        vecs[7]  = '{2'b11, 8'd0,   8'd0,   8'd0,   1'b0};
        vecs[8]  = '{2'b10, 8'd128, 8'd128, 8'd255, 1'b1};
        vecs[9]  = '{2'b00, 8'd255, 8'd1,   8'd0,   1'b1};
        vecs[10] = '{2'b01, 8'd0,   8'd255, 8'd1,   1'b1};
        vecs[11] = '{2'b11, 8'd200, 8'd199, 8'd1,   1'b0};

        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_y", y, 0);
        check("rst_ovf", ovf, 0);
        check("rst_ovf_cnt", ovf_cnt, 0);
        check("rst_in_ready", in_ready, 1);

        // Single transactions: latency 1 edge after acceptance, then transfer.
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            op = vecs[i].op; a = vecs[i].a; b = vecs[i].b; in_valid = 1'b1;
            #1;
            check($sformatf("vec%0d_in_ready", i), in_ready, 1);
            tick();
            in_valid = 1'b0;
            check($sformatf("vec%0d_early", i), out_valid, 0);
            tick();
            check($sformatf("vec%0d_valid", i), out_valid, 1);
            check($sformatf("vec%0d_y", i), y, vecs[i].y);
            check($sformatf("vec%0d_ovf", i), ovf, vecs[i].ovf);
            tick();
            if (vecs[i].ovf) cnt_m = sat_inc(cnt_m);
            check($sformatf("vec%0d_cnt", i), ovf_cnt, cnt_m);
            check($sformatf("vec%0d_drained", i), out_valid, 0);
        end

        // Back-to-back throughput with out_ready held high.
        op = 2'b00;
        for (int j = 0; j < 6; j++) begin
            if (j < 5) begin
                a = 8'(j * 50); b = 8'd100; in_valid = 1'b1;
                #1;
                check($sformatf("tp%0d_in_ready", j), in_ready, 1);
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (j >= 1) begin
                s = (j - 1) * 50 + 100;
                check($sformatf("tp%0d_valid", j), out_valid, 1);
                check($sformatf("tp%0d_y", j), y, s % 256);
                check($sformatf("tp%0d_ovf", j), ovf, (s > 255) ? 1 : 0);
                if (s > 255) cnt_m = sat_inc(cnt_m);
            end
        end
        tick();
        check("tp_cnt", ovf_cnt, cnt_m);
        check("tp_empty", out_valid, 0);

        // Backpressure: only STAGES results fit.
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            a = 8'(i * 10 + 1); b = 8'(i); in_valid = 1'b1;
            #1;
            if (in_ready) expq.push_back(i * 11 + 1);
            tick();
        end
        in_valid = 1'b0;
        #1;
        check("bp_accepted", expq.size(), 2);
        check("bp_in_ready", in_ready, 0);
        repeat (2) tick();
        check("bp_stall_valid", out_valid, 1);
        check("bp_stall_y", y, 1);
        out_ready = 1'b1;
        #1;
        check("bp_in_ready_comb", in_ready, 1);
        for (int c = 0; c < 6 && expq.size() > 0; c++) begin
            check($sformatf("bp_drain%0d_valid", c), out_valid, 1);
            check($sformatf("bp_drain%0d_y", c), y, expq[0]);
            void'(expq.pop_front());
            tick();
        end
        check("bp_drain_empty", out_valid, 0);

        // Flush with two results in flight and a new input presented.
        out_ready = 1'b0; a = 8'd200; b = 8'd100; op = 2'b00; in_valid = 1'b1;
        tick();
        tick();
        a = 8'd1; b = 8'd1; flush = 1'b1; out_ready = 1'b1;
        #1;
        check("fl_in_ready", in_ready, 0);
        tick();
        cnt_m = sat_inc(cnt_m);
        flush = 1'b0; in_valid = 1'b0;
        check("fl_out_valid", out_valid, 0);
        seen = 1'b0;
        repeat (4) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check("fl_nothing_emerges", seen, 0);
        check("fl_cnt", ovf_cnt, cnt_m);

        // Counter saturation.
        a = 8'd255; b = 8'd1; op = 2'b00; in_valid = 1'b1; out_ready = 1'b1;
        repeat (17) begin
            tick();
            cnt_m = sat_inc(cnt_m);
        end
        in_valid = 1'b0;
        repeat (3) tick();
        check("sat_cnt", ovf_cnt, 15);
        check("sat_model", ovf_cnt, cnt_m);

        // cnt_clr beats a same-cycle overflowing transfer.
        out_ready = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            if (out_valid) seen = 1'b1;
            else tick();
        end
        check("clr_wait_valid", seen, 1);
        check("clr_ovf", ovf, 1);
        out_ready = 1'b1; cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0; cnt_m = 0;
        check("clr_cnt", ovf_cnt, 0);
        check("clr_transferred", out_valid, 0);

        // Asynchronous reset mid-burst.
        a = 8'd255; b = 8'd1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        cnt_m = 1;
        check("pre_rst_cnt", ovf_cnt, cnt_m);
        out_ready = 1'b0; a = 8'd200; b = 8'd100; in_valid = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        check("pre_rst_valid", out_valid, 1);
        check("pre_rst_y", y, 44);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_y", y, 0);
        check("rst_mid_ovf", ovf, 0);
        check("rst_mid_cnt", ovf_cnt, 0);
        cnt_m = 0;
        #2 rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", in_ready, 1);
        out_ready = 1'b1; op = 2'b01; a = 8'd5; b = 8'd9; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check("post_rst_valid", out_valid, 1);
        check("post_rst_y", y, 252);
        check("post_rst_ovf", ovf, 1);
        tick();
        cnt_m = sat_inc(cnt_m);
        check("post_rst_cnt", ovf_cnt, cnt_m);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
